// File: rtl/keypress_pkg.sv
// Shared keycodes, command encodings, repeat FSM states and keycode decoder
// for the keypress_queue front-end.
package keypress_pkg;

  localparam logic [7:0] KEY_UP      = 8'h1D;
  localparam logic [7:0] KEY_LEFT    = 8'h1C;
  localparam logic [7:0] KEY_DOWN    = 8'h1B;
  localparam logic [7:0] KEY_RIGHT   = 8'h23;
  localparam logic [7:0] KEY_ACTION  = 8'h2C;
  localparam logic [7:0] KEY_CONFIRM = 8'h28;

  typedef enum logic [2:0] {
    CMD_NONE    = 3'b000,
    CMD_UP      = 3'b001,
    CMD_LEFT    = 3'b010,
    CMD_CONFIRM = 3'b011,
    CMD_DOWN    = 3'b100,
    CMD_RIGHT   = 3'b101,
    CMD_ACTION  = 3'b110
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } repeat_state_t;

  // Unmapped codes (including 0 = no key) decode to CMD_NONE.
  function automatic cmd_t decode_key(input logic [7:0] code);
    cmd_t cmd;
    case (code)
      KEY_UP:      cmd = CMD_UP;
      KEY_LEFT:    cmd = CMD_LEFT;
      KEY_DOWN:    cmd = CMD_DOWN;
      KEY_RIGHT:   cmd = CMD_RIGHT;
      KEY_ACTION:  cmd = CMD_ACTION;
      KEY_CONFIRM: cmd = CMD_CONFIRM;
      default:     cmd = CMD_NONE;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO with power-of-two depth; owns pointer wrap and the
// simultaneous push/pop rules (push accepted when full only alongside a pop).
module cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CMD_W = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [CMD_W-1:0]         din,
  output logic [CMD_W-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [CMD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/keypress_queue.sv
// Keyboard command front-end: press edge detect, keycode decode and command FIFO.
// Define KEYPRESS_REPEAT_EN to compile in the auto-repeat FSM for held keys.
module keypress_queue
  import keypress_pkg::*;
#(
  parameter int unsigned KEYCODE_W     = 8,
  parameter int unsigned CMD_W         = 3,
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned REPEAT_DELAY  = 25_000_000,
  parameter int unsigned REPEAT_PERIOD = 5_000_000
) (
  input  logic                   CLOCK_50,
  input  logic                   RESET,
  input  logic [KEYCODE_W-1:0]   KEYCODE,
  input  logic                   GET_INPUT,
  output logic [CMD_W-1:0]       USER_INPUT,
  output logic                   INPUT_VALID,
  output logic [$clog2(DEPTH):0] COUNT,
  output logic                   OVERFLOW
);

  localparam int unsigned KW = (KEYCODE_W > 8) ? KEYCODE_W : 8;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("keypress_queue: invalid parameter set");
  end

  logic [KEYCODE_W-1:0] key_q;
  logic [KW-1:0]        key_ext;
  cmd_t                 key_cmd;
  logic                 key_changed;
  logic                 press;
  logic                 push;
  logic [CMD_W-1:0]     push_cmd;
  logic                 full;
  logic                 empty;

  // Codes wider than 8 bits only decode when the upper bits are zero.
  assign key_ext     = KW'(KEYCODE);
  assign key_cmd     = ((key_ext >> 8) == '0) ? decode_key(key_ext[7:0]) : CMD_NONE;
  assign key_changed = (KEYCODE != key_q);
  assign press       = (key_cmd != CMD_NONE) && key_changed;
  assign push_cmd    = CMD_W'(key_cmd);

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) key_q <= '0;
    else       key_q <= KEYCODE;
  end

`ifdef KEYPRESS_REPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

  repeat_state_t    rpt_state;
  repeat_state_t    rpt_next;
  logic [RPT_W-1:0] rpt_cnt;
  logic [RPT_W-1:0] rpt_cnt_next;
  logic             rpt_push;

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      rpt_state <= IDLE;
      rpt_cnt   <= '0;
    end else begin
      rpt_state <= rpt_next;
      rpt_cnt   <= rpt_cnt_next;
    end
  end

  // A fresh press restarts the delay; any change or release drops to IDLE.
  always_comb begin
    rpt_next     = rpt_state;
    rpt_cnt_next = rpt_cnt;
    rpt_push     = 1'b0;
    if (press) begin
      rpt_next     = DELAY;
      rpt_cnt_next = '0;
    end else if (key_changed || key_cmd == CMD_NONE) begin
      rpt_next     = IDLE;
      rpt_cnt_next = '0;
    end else begin
      case (rpt_state)
        DELAY: begin
          if (rpt_cnt == RPT_W'(REPEAT_DELAY - 1)) begin
            rpt_push     = 1'b1;
            rpt_next     = REPEAT;
            rpt_cnt_next = '0;
          end else begin
            rpt_cnt_next = rpt_cnt + RPT_W'(1);
          end
        end
        REPEAT: begin
          if (rpt_cnt == RPT_W'(REPEAT_PERIOD - 1)) begin
            rpt_push     = 1'b1;
            rpt_cnt_next = '0;
          end else begin
            rpt_cnt_next = rpt_cnt + RPT_W'(1);
          end
        end
        default: begin
          rpt_next     = IDLE;
          rpt_cnt_next = '0;
        end
      endcase
    end
  end

  assign push = press || rpt_push;
`else
  assign push = press;
`endif

  cmd_fifo #(
    .DEPTH (DEPTH),
    .CMD_W (CMD_W)
  ) u_fifo (
    .clk   (CLOCK_50),
    .rst   (RESET),
    .push  (push),
    .pop   (GET_INPUT),
    .din   (push_cmd),
    .dout  (USER_INPUT),
    .count (COUNT),
    .full  (full),
    .empty (empty)
  );

  assign INPUT_VALID = !empty;

  // Sticky: a push dropped because the queue is full with no pop freeing a slot.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET)                          OVERFLOW <= 1'b0;
    else if (push && full && !GET_INPUT) OVERFLOW <= 1'b1;
  end

endmodule

// File: tb/tb_keypress_queue.sv
// Scoreboard bench for keypress_queue: the driver queues expected commands,
// a monitor compares them whenever the consumer pops a valid head entry.
module tb_keypress_queue;

  localparam int DEPTH = 4;
`ifdef KEYPRESS_REPEAT_EN
  localparam int T1_CNT = 2;
  localparam int T5_CNT = 4;
`else
  localparam int T1_CNT = 1;
  localparam int T5_CNT = 1;
`endif

  logic       CLOCK_50;
  logic       RESET;
  logic [7:0] KEYCODE;
  logic       GET_INPUT;
  logic [2:0] USER_INPUT;
  logic       INPUT_VALID;
  logic [2:0] COUNT;
  logic       OVERFLOW;

  int         checks = 0;
  int         errors = 0;
  logic [2:0] exp_q[$];

  keypress_queue #(
    .KEYCODE_W     (8),
    .CMD_W         (3),
    .DEPTH         (DEPTH),
    .REPEAT_DELAY  (8),
    .REPEAT_PERIOD (4)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .RESET       (RESET),
    .KEYCODE     (KEYCODE),
    .GET_INPUT   (GET_INPUT),
    .USER_INPUT  (USER_INPUT),
    .INPUT_VALID (INPUT_VALID),
    .COUNT       (COUNT),
    .OVERFLOW    (OVERFLOW)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // Monitor: every popped head must match the oldest expected command.
  always @(negedge CLOCK_50) begin
    if (!RESET && GET_INPUT && INPUT_VALID) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got %0d, expected no entry", USER_INPUT);
      end else begin
        logic [2:0] e;
        e = exp_q.pop_front();
        if (USER_INPUT !== e) begin
          errors++;
          $display("FAIL pop_data: got %b, expected %b", USER_INPUT, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic idle(input logic [7:0] code, input int n);
    KEYCODE = code;
    repeat (n) tick();
  endtask

  task automatic pop_n(input int k);
    GET_INPUT = 1'b1;
    repeat (k) tick();
    GET_INPUT = 1'b0;
  endtask

  // Hold a new mapped key for n cycles; optionally pop during the first cycle.
  task automatic press(input logic [7:0] code, input logic [2:0] c, input int n, input bit pop_first);
    KEYCODE = code;
    for (int i = 0; i < n; i++) begin
      bit hit;
      hit = (i == 0);
`ifdef KEYPRESS_REPEAT_EN
      hit = hit || (i >= 8 && ((i - 8) % 4) == 0);
`endif
      GET_INPUT = pop_first && (i == 0);
      if (hit && (exp_q.size() < DEPTH || GET_INPUT)) exp_q.push_back(c);
      tick();
    end
    GET_INPUT = 1'b0;
  endtask

  initial begin
    RESET = 1'b1;
    KEYCODE = 8'h00;
    GET_INPUT = 1'b0;
    tick();
    tick();
    chk("reset_count", COUNT, 0);
    chk("reset_valid", INPUT_VALID, 0);
    chk("reset_user_input", USER_INPUT, 0);
    chk("reset_overflow", OVERFLOW, 0);
    RESET = 1'b0;
    tick();

    // Held key yields one press
    press(8'h1D, 3'b001, 10, 1'b0);
    idle(8'h00, 1);
    chk("hold_count", COUNT, T1_CNT);
    chk("hold_head", USER_INPUT, 3'b001);
    chk("hold_valid", INPUT_VALID, 1);
    pop_n(T1_CNT);
    chk("hold_valid_after_pop", INPUT_VALID, 0);
    chk("hold_head_after_pop", USER_INPUT, 0);

    // Mapped-to-mapped change, release and unmapped code
    press(8'h1C, 3'b010, 2, 1'b0);
    press(8'h23, 3'b101, 2, 1'b0);
    idle(8'h00, 2);
    idle(8'h55, 2);
    press(8'h1B, 3'b100, 2, 1'b0);
    idle(8'h00, 1);
    chk("seq_count", COUNT, 3);
    pop_n(3);
    chk("seq_count_after_pop", COUNT, 0);

    // Push and pop together on an empty queue
    press(8'h2C, 3'b110, 2, 1'b1);
    chk("empty_pushpop_count", COUNT, 1);
    pop_n(1);
    idle(8'h00, 1);
    chk("empty_pushpop_drained", COUNT, 0);

    // Push and pop together on a full queue
    press(8'h1D, 3'b001, 2, 1'b0);
    press(8'h1C, 3'b010, 2, 1'b0);
    press(8'h1B, 3'b100, 2, 1'b0);
    press(8'h23, 3'b101, 2, 1'b0);
    chk("fill_count", COUNT, 4);
    press(8'h28, 3'b011, 2, 1'b1);
    idle(8'h00, 1);
    chk("full_pushpop_count", COUNT, 4);
    chk("full_pushpop_overflow", OVERFLOW, 0);
    pop_n(6);
    chk("overpop_count", COUNT, 0);
    chk("overpop_valid", INPUT_VALID, 0);

    // Long hold: repeats only when the repeat FSM is built in
    press(8'h2C, 3'b110, 17, 1'b0);
    idle(8'h00, 6);
    chk("long_hold_count", COUNT, T5_CNT);
    chk("long_hold_overflow", OVERFLOW, 0);
    pop_n(T5_CNT + 1);

    // Asynchronous reset mid-hold
    press(8'h1C, 3'b010, 2, 1'b0);
    press(8'h1B, 3'b100, 2, 1'b0);
    press(8'h1D, 3'b001, 2, 1'b0);
    chk("pre_reset_count", COUNT, 3);
    #2 RESET = 1'b1;
    #1;
    chk("async_reset_count", COUNT, 0);
    chk("async_reset_valid", INPUT_VALID, 0);
    chk("async_reset_user_input", USER_INPUT, 0);
    exp_q.delete();
    tick();
    RESET = 1'b0;
    exp_q.push_back(3'b001);
    tick();
    tick();
    idle(8'h00, 1);
    chk("post_reset_count", COUNT, 1);
    chk("post_reset_head", USER_INPUT, 3'b001);
    pop_n(1);

    // Overflow: fifth press dropped
    press(8'h1D, 3'b001, 2, 1'b0);
    press(8'h1C, 3'b010, 2, 1'b0);
    press(8'h1B, 3'b100, 2, 1'b0);
    press(8'h23, 3'b101, 2, 1'b0);
    press(8'h2C, 3'b110, 2, 1'b0);
    idle(8'h00, 2);
    chk("overflow_count", COUNT, 4);
    chk("overflow_flag", OVERFLOW, 1);
    pop_n(4);
    chk("overflow_drained", COUNT, 0);
    chk("overflow_sticky", OVERFLOW, 1);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
